// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the word-wide UART transmitter: word width, default
// baud divisor and the serializer state encoding.
package uart_word_tx_pkg;

  localparam int WORD_WIDTH           = 16;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 115200 baud from 50 MHz

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// Byte serializer: 8N1 framing with a per-bit baud counter. A new byte is taken
// from IDLE or at the last cycle of STOP, so back-to-back bytes have no gap.
module uart_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx,
  output logic       idle
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       data_reg, data_next;
  logic             tx_reg, tx_next;
  logic             bit_end;

  assign bit_end = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      data_reg    <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      data_reg    <= data_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    data_next    = data_reg;
    byte_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        byte_ready = 1'b1;
        cnt_next   = '0;
        if (byte_valid) begin
          state_next = START;
          data_next  = byte_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          cnt_next     = '0;
          bit_idx_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          byte_ready = 1'b1;
          cnt_next   = '0;
          if (byte_valid) begin
            state_next = START;
            data_next  = byte_data;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is registered from the current state, so tx trails the FSM
  // by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[bit_idx_reg];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx   = tx_reg;
  assign idle = (state_reg == IDLE);

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: a small word FIFO feeding a byte serializer,
// high byte first then low byte, with no idle gap while words are queued.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_WIDTH-1:0]       word,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  word_ready_reg;
  logic                  byte_sel_reg;   // 1: low byte of the popped word is pending
  logic [7:0]            low_byte_reg;
  logic [WORD_WIDTH-1:0] head_word;

  logic       push, pop;
  logic       byte_valid, byte_ready, byte_accept;
  logic [7:0] byte_data;
  logic       ser_idle;

  assign head_word   = fifo_mem[rd_ptr_reg];
  assign push        = word_valid && word_ready_reg;
  assign byte_valid  = byte_sel_reg || (count_reg != '0);
  assign byte_data   = byte_sel_reg ? low_byte_reg : head_word[WORD_WIDTH-1 -: 8];
  assign byte_accept = byte_valid && byte_ready;
  assign pop         = byte_accept && !byte_sel_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= word;
    end
  end

  // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      word_ready_reg <= 1'b0;
      byte_sel_reg   <= 1'b0;
      low_byte_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        low_byte_reg <= head_word[7:0];
      end
      if (byte_accept) begin
        byte_sel_reg <= !byte_sel_reg;
      end
      count_reg      <= count_next;
      word_ready_reg <= (count_next != FULL_COUNT);
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx        (tx),
    .idle      (ser_idle)
  );

  assign word_ready = word_ready_reg;
  assign fifo_count = count_reg;
  assign busy       = !ser_idle || (count_reg != '0);

endmodule
